cardinal_dmem_arbiter: RTL and testbench
========================================

# cardinal_dmem_arbiter

- Sits between the cardinal core's data-memory port and the single-port DMEM.
- Shares the DMEM with a second requester, the network-interface (NIC) DMA port.
- The core has fixed priority. A starvation counter forces a NIC slot after `STARVE_MAX` consecutive denials; in that slot the core is held with `Core_Stall`.
- The arbiter tags each read so that returned data reaches only the requester that issued it.

## Interface

Parameters:
- `ADDR_W`, default 8: DMEM word-address width
- `DATA_W`, default 64: DMEM data width
- `STARVE_MAX`, default 4: consecutive NIC denials before a forced NIC grant; legal range 1..15

Ports (vectors MSB-first, `[0:W-1]`):
- `Clock`  in  1  clock
- `Reset`  in  1  reset; Reset, synchronous, active-high; clock Clock
- `Core_En`  in  1  core memory access request (load or store)
- `Core_WrEn`  in  1  core store when 1, load when 0
- `Core_Addr`  in  `ADDR_W`  core address
- `Core_Wdata`  in  `DATA_W`  core store data
- `Core_Rdata`  out  `DATA_W`  load data to core
- `Core_Stall`  out  1  core access not taken this cycle; core must hold its request
- `Nic_Req`  in  1  NIC access request
- `Nic_WrEn`  in  1  NIC write when 1, read when 0
- `Nic_Addr`  in  `ADDR_W`  NIC address
- `Nic_Wdata`  in  `DATA_W`  NIC write data
- `Nic_Gnt`  out  1  NIC request accepted this cycle
- `Nic_Rdata`  out  `DATA_W`  NIC read data
- `Nic_Rvalid`  out  1  `Nic_Rdata` valid
- `Mem_En`, `Mem_WrEn`  out  1 each  DMEM enable and write enable
- `Mem_Addr`  out  `ADDR_W`  DMEM address
- `Mem_Wdata`  out  `DATA_W`  DMEM write data
- `Mem_Rdata`  in  `DATA_W`  DMEM read data, valid 1 cycle after a read

## Operation

- **Grant decision.** Combinational each cycle; exactly one owner per cycle.
- **State `PRIO_CORE`:**
  - Core wins whenever `Core_En=1`.
  - NIC is granted only when `Core_En=0` and `Nic_Req=1`.
- **State `FORCE_NIC`:**
  - NIC wins if `Nic_Req=1`.
  - `Core_Stall` = `Core_En`.
  - If `Nic_Req` has dropped, the slot reverts to core priority that cycle and no stall is raised.
- **Memory mux.** The winner's `En`/`WrEn`/`Addr`/`Wdata` drive the `Mem_*` outputs. If there is no winner, `Mem_En=0` and the other `Mem_*` outputs hold 0.
- **Starvation counter** (4 bits, saturating at `STARVE_MAX`):
  - Increments on each cycle with `Nic_Req & ~Nic_Gnt`.
  - Clears on `Nic_Gnt` or `~Nic_Req`.
- **State transitions:**
  - `PRIO_CORE` → `FORCE_NIC` when the counter's next value equals `STARVE_MAX`.
  - `FORCE_NIC` → `PRIO_CORE` unconditionally after one cycle.
- **Read tag.** Registered 2-bit `{valid, owner}`, set from the granted read. In the next cycle:
  - owner NIC → `Nic_Rvalid=1`, `Nic_Rdata=Mem_Rdata`;
  - owner core → `Core_Rdata=Mem_Rdata`.
- **Rdata defaults.** When the tag does not select a port, that port's `Rdata` is 0.
- **Writes** never set the tag.

## Timing

- **Reset:**
  - State `PRIO_CORE`, counter 0, tag invalid.
  - All outputs 0: `Core_Stall`, `Nic_Gnt`, `Nic_Rvalid`, both `Rdata` ports, all `Mem_*`.
- **Latencies:**
  - Grant, stall and the `Mem_*` outputs are combinational from the requests plus registered state: 0-cycle.
  - Read data on either port follows its grant by exactly 1 cycle.
- **Handshakes:**
  - NIC transfer occurs on a rising edge with `Nic_Req & Nic_Gnt`.
  - NIC must hold `Req` and its payload until granted.
  - Core holds its request while `Core_Stall=1`.
- **Simultaneous core and NIC requests:** core wins unless the state is `FORCE_NIC`.
- **Back-to-back reads** from alternating owners are allowed; the tag updates every cycle.
- **Reset during an outstanding read:** `Nic_Rvalid=0` on the following cycle; the data is dropped.
- **`STARVE_MAX` bound:** the NIC waits at most `STARVE_MAX` cycles between request and grant.

## Structure

- A shared package `cardinal_pkg` holds:
  - the state encoding (`PRIO_CORE=1'b0`, `FORCE_NIC=1'b1`);
  - the owner encoding (`OWN_CORE=0`, `OWN_NIC=1`);
  - the `ADDR_W`/`DATA_W` defaults shared with `cardinal_processor`.
- One sub-module, `starve_counter`: saturating counter with `inc`, `clr` and `at_max` outputs.
- Everything else stays flat in this module.

## Test plan

- **Reset check:** hold `Reset` 2 cycles with both requesters active → all outputs 0; first post-reset cycle grants the core.
- **Core-only load:** core reads addr 0x10 holding 0xDEADBEEF_00000001 → `Mem_En=1`, `WrEn=0` in cycle N; `Core_Rdata=0xDEADBEEF_00000001` in N+1; `Nic_Rvalid=0`.
- **NIC-only write:** NIC writes 0x55 to addr 0x20 → `Nic_Gnt=1` same cycle; `Mem_WrEn=1`, `Mem_Addr=0x20`; no `Rvalid`.
- **Starvation, `STARVE_MAX=4`:** core loads every cycle, NIC read pending from cycle 0.
  - Cycles 0–3: core granted.
  - Cycle 4: `Nic_Gnt=1`, `Core_Stall=1`.
  - Cycle 5: `Nic_Rvalid=1`, core granted again.
- **Forced slot with `Nic_Req` dropped:** `Nic_Req` drops in the `FORCE_NIC` cycle → core granted, `Core_Stall=0`, counter 0.
- **Reset mid-read:** assert `Reset` the cycle after a NIC read grant → `Nic_Rvalid=0`, `Nic_Rdata=0`.

Source files
------------

// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal processor slice: arbiter state and
// read-owner encodings plus the memory geometry defaults.
package cardinal_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 64;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    PRIO_CORE = 1'b0,
    FORCE_NIC = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_NIC  = 1'b1
  } owner_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive NIC denials; at_max flags that the count
// about to be registered has reached MAX.
module starve_counter
  import cardinal_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [STARVE_CNT_W-1:0] count_q;
  logic [STARVE_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != STARVE_CNT_W'(MAX))) begin
      count_d = count_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Looking at the next value lets the forced slot land on the very next cycle.
  assign at_max = (count_d == STARVE_CNT_W'(MAX));

endmodule

// File: rtl/cardinal_dmem_arbiter.sv
// Shares the single-port DMEM between the cardinal core (fixed priority) and
// the NIC DMA port, with a starvation-forced NIC slot and tagged read return.
module cardinal_dmem_arbiter
  import cardinal_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Core_En,
  input  logic              Core_WrEn,
  input  logic [0:ADDR_W-1] Core_Addr,
  input  logic [0:DATA_W-1] Core_Wdata,
  output logic [0:DATA_W-1] Core_Rdata,
  output logic              Core_Stall,
  input  logic              Nic_Req,
  input  logic              Nic_WrEn,
  input  logic [0:ADDR_W-1] Nic_Addr,
  input  logic [0:DATA_W-1] Nic_Wdata,
  output logic              Nic_Gnt,
  output logic [0:DATA_W-1] Nic_Rdata,
  output logic              Nic_Rvalid,
  output logic              Mem_En,
  output logic              Mem_WrEn,
  output logic [0:ADDR_W-1] Mem_Addr,
  output logic [0:DATA_W-1] Mem_Wdata,
  input  logic [0:DATA_W-1] Mem_Rdata
);

  arb_state_t state_q;
  arb_state_t state_d;
  logic       nic_force;
  logic       nic_win;
  logic       core_win;
  logic       starve_inc;
  logic       starve_clr;
  logic       starve_at_max;
  logic       tag_valid_q;
  logic       tag_valid_d;
  owner_t     tag_owner_q;
  owner_t     tag_owner_d;

  // Grant and memory mux; Reset silences every output in the same cycle.
  always_comb begin
    nic_force  = (state_q == FORCE_NIC) && Nic_Req;
    nic_win    = 1'b0;
    core_win   = 1'b0;
    Core_Stall = 1'b0;
    Nic_Gnt    = 1'b0;
    Mem_En     = 1'b0;
    Mem_WrEn   = 1'b0;
    Mem_Addr   = '0;
    Mem_Wdata  = '0;
    if (!Reset) begin
      nic_win    = nic_force || (!Core_En && Nic_Req);
      core_win   = Core_En && !nic_force;
      Core_Stall = nic_force && Core_En;
      Nic_Gnt    = nic_win;
      if (core_win) begin
        Mem_En    = 1'b1;
        Mem_WrEn  = Core_WrEn;
        Mem_Addr  = Core_Addr;
        Mem_Wdata = Core_Wdata;
      end else if (nic_win) begin
        Mem_En    = 1'b1;
        Mem_WrEn  = Nic_WrEn;
        Mem_Addr  = Nic_Addr;
        Mem_Wdata = Nic_Wdata;
      end
    end
  end

  assign starve_inc = Nic_Req && !nic_win;
  assign starve_clr = !starve_inc;

  starve_counter #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .at_max(starve_at_max)
  );

  // The forced slot lasts exactly one cycle whether or not the NIC used it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRIO_CORE: if (starve_at_max) state_d = FORCE_NIC;
      FORCE_NIC: state_d = PRIO_CORE;
      default:   state_d = PRIO_CORE;
    endcase
  end

  always_comb begin
    tag_valid_d = (core_win && !Core_WrEn) || (nic_win && !Nic_WrEn);
    tag_owner_d = nic_win ? OWN_NIC : OWN_CORE;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= PRIO_CORE;
      tag_valid_q <= 1'b0;
      tag_owner_q <= OWN_CORE;
    end else begin
      state_q     <= state_d;
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  // Returned data is steered only to the port that issued the read.
  always_comb begin
    Core_Rdata = '0;
    Nic_Rdata  = '0;
    Nic_Rvalid = 1'b0;
    if (!Reset && tag_valid_q) begin
      if (tag_owner_q == OWN_NIC) begin
        Nic_Rdata  = Mem_Rdata;
        Nic_Rvalid = 1'b1;
      end else begin
        Core_Rdata = Mem_Rdata;
      end
    end
  end

endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
// Directed bench for cardinal_dmem_arbiter: a cycle-by-cycle vector table plus
// hand sequences for the dropped forced slot and reset during a NIC read.
module tb_cardinal_dmem_arbiter;

  localparam logic [63:0] DB = 64'hDEADBEEF_00000001;
  localparam logic [63:0] W6 = 64'h01234567_89ABCDEF;

  logic        Clock;
  logic        Reset;
  logic        Core_En, Core_WrEn;
  logic [7:0]  Core_Addr;
  logic [63:0] Core_Wdata, Core_Rdata;
  logic        Core_Stall;
  logic        Nic_Req, Nic_WrEn;
  logic [7:0]  Nic_Addr;
  logic [63:0] Nic_Wdata, Nic_Rdata;
  logic        Nic_Gnt, Nic_Rvalid;
  logic        Mem_En, Mem_WrEn;
  logic [7:0]  Mem_Addr;
  logic [63:0] Mem_Wdata, Mem_Rdata;

  int errors = 0;
  int checks = 0;

  cardinal_dmem_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .Core_En(Core_En), .Core_WrEn(Core_WrEn), .Core_Addr(Core_Addr),
    .Core_Wdata(Core_Wdata), .Core_Rdata(Core_Rdata), .Core_Stall(Core_Stall),
    .Nic_Req(Nic_Req), .Nic_WrEn(Nic_WrEn), .Nic_Addr(Nic_Addr),
    .Nic_Wdata(Nic_Wdata), .Nic_Gnt(Nic_Gnt), .Nic_Rdata(Nic_Rdata),
    .Nic_Rvalid(Nic_Rvalid),
    .Mem_En(Mem_En), .Mem_WrEn(Mem_WrEn), .Mem_Addr(Mem_Addr),
    .Mem_Wdata(Mem_Wdata), .Mem_Rdata(Mem_Rdata)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Unwritten words read back as C0DE..<addr>, except 0x10 which holds DB.
  function automatic logic [63:0] m(input logic [7:0] a);
    return (a == 8'h10) ? DB : (64'hC0DE_0000_0000_0000 | 64'(a));
  endfunction

  logic [63:0] mem [0:255];
  bit          wr_valid [0:255];

  // One-cycle read latency DMEM; holds its last read data when idle.
  always @(posedge Clock) begin
    if (Mem_En && Mem_WrEn) begin
      mem[Mem_Addr]      <= Mem_Wdata;
      wr_valid[Mem_Addr] <= 1'b1;
    end
    if (Mem_En && !Mem_WrEn)
      Mem_Rdata <= wr_valid[Mem_Addr] ? mem[Mem_Addr] : m(Mem_Addr);
  end

  typedef struct {
    logic        rst, ce, cw;
    logic [7:0]  ca;
    logic [63:0] cd;
    logic        nr, nw;
    logic [7:0]  na;
    logic [63:0] nd;
    logic        xs, xg, xe, xw;
    logic [7:0]  xa;
    logic [63:0] xd, xc, xn;
    logic        xv;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, ce, cw, input logic [7:0] ca, input logic [63:0] cd,
    input logic nr, nw, input logic [7:0] na, input logic [63:0] nd,
    input logic xs, xg, xe, xw, input logic [7:0] xa, input logic [63:0] xd,
    input logic [63:0] xc, xn, input logic xv);
    vec_t v;
    v.rst = rst; v.ce = ce; v.cw = cw; v.ca = ca; v.cd = cd;
    v.nr = nr; v.nw = nw; v.na = na; v.nd = nd;
    v.xs = xs; v.xg = xg; v.xe = xe; v.xw = xw; v.xa = xa; v.xd = xd;
    v.xc = xc; v.xn = xn; v.xv = xv;
    return v;
  endfunction

  task automatic apply_stimulus(
    input logic rst, ce, cw, input logic [7:0] ca, input logic [63:0] cd,
    input logic nr, nw, input logic [7:0] na, input logic [63:0] nd);
    @(posedge Clock);
    #1;
    Reset = rst; Core_En = ce; Core_WrEn = cw; Core_Addr = ca; Core_Wdata = cd;
    Nic_Req = nr; Nic_WrEn = nw; Nic_Addr = na; Nic_Wdata = nd;
    @(negedge Clock);
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t tbl [19];

  initial begin
    //          rst ce cw ca     cd  nr nw na     nd     xs xg xe xw xa     xd     xc     xn     xv
    tbl[0]  = mk(1, 1, 0, 8'h10, 0,  1, 0, 8'h40, 0,     0, 0, 0, 0, 8'h00, 0,     0,     0,     0);
    tbl[1]  = mk(1, 1, 0, 8'h10, 0,  1, 0, 8'h40, 0,     0, 0, 0, 0, 8'h00, 0,     0,     0,     0);
    tbl[2]  = mk(0, 1, 0, 8'h10, 0,  1, 0, 8'h40, 0,     0, 0, 1, 0, 8'h10, 0,     0,     0,     0);
    tbl[3]  = mk(0, 0, 0, 8'h00, 0,  0, 0, 8'h00, 0,     0, 0, 0, 0, 8'h00, 0,     DB,    0,     0);
    tbl[4]  = mk(0, 0, 0, 8'h00, 0,  1, 1, 8'h20, 64'h55, 0, 1, 1, 1, 8'h20, 64'h55, 0,    0,     0);
    tbl[5]  = mk(0, 0, 0, 8'h00, 0,  1, 0, 8'h20, 0,     0, 1, 1, 0, 8'h20, 0,     0,     0,     0);
    tbl[6]  = mk(0, 1, 1, 8'h30, W6, 0, 0, 8'h00, 0,     0, 0, 1, 1, 8'h30, W6,    0,     64'h55, 1);
    tbl[7]  = mk(0, 1, 0, 8'h30, 0,  0, 0, 8'h00, 0,     0, 0, 1, 0, 8'h30, 0,     0,     0,     0);
    tbl[8]  = mk(0, 1, 0, 8'h11, 0,  1, 0, 8'h40, 0,     0, 0, 1, 0, 8'h11, 0,     W6,    0,     0);
    tbl[9]  = mk(0, 1, 0, 8'h12, 0,  1, 0, 8'h40, 0,     0, 0, 1, 0, 8'h12, 0,     m(8'h11), 0,  0);
    tbl[10] = mk(0, 1, 0, 8'h13, 0,  1, 0, 8'h40, 0,     0, 0, 1, 0, 8'h13, 0,     m(8'h12), 0,  0);
    tbl[11] = mk(0, 1, 0, 8'h14, 0,  1, 0, 8'h40, 0,     0, 0, 1, 0, 8'h14, 0,     m(8'h13), 0,  0);
    tbl[12] = mk(0, 1, 0, 8'h14, 0,  1, 0, 8'h40, 0,     1, 1, 1, 0, 8'h40, 0,     m(8'h14), 0,  0);
    tbl[13] = mk(0, 1, 0, 8'h14, 0,  0, 0, 8'h00, 0,     0, 0, 1, 0, 8'h14, 0,     0,  m(8'h40), 1);
    tbl[14] = mk(0, 0, 0, 8'h00, 0,  0, 0, 8'h00, 0,     0, 0, 0, 0, 8'h00, 0,     m(8'h14), 0,  0);
    tbl[15] = mk(0, 0, 0, 8'h00, 0,  1, 0, 8'h41, 0,     0, 1, 1, 0, 8'h41, 0,     0,     0,     0);
    tbl[16] = mk(0, 1, 0, 8'h15, 0,  0, 0, 8'h00, 0,     0, 0, 1, 0, 8'h15, 0,     0,  m(8'h41), 1);
    tbl[17] = mk(0, 0, 0, 8'h00, 0,  1, 0, 8'h42, 0,     0, 1, 1, 0, 8'h42, 0,     m(8'h15), 0,  0);
    tbl[18] = mk(0, 0, 0, 8'h00, 0,  0, 0, 8'h00, 0,     0, 0, 0, 0, 8'h00, 0,     0,  m(8'h42), 1);

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(tbl[i].rst, tbl[i].ce, tbl[i].cw, tbl[i].ca, tbl[i].cd,
                     tbl[i].nr, tbl[i].nw, tbl[i].na, tbl[i].nd);
      check_output($sformatf("r%0d_stall", i), 64'(Core_Stall), 64'(tbl[i].xs));
      check_output($sformatf("r%0d_gnt", i), 64'(Nic_Gnt), 64'(tbl[i].xg));
      check_output($sformatf("r%0d_mem_en_wr", i), 64'({Mem_En, Mem_WrEn}), 64'({tbl[i].xe, tbl[i].xw}));
      check_output($sformatf("r%0d_mem_addr", i), 64'(Mem_Addr), 64'(tbl[i].xa));
      check_output($sformatf("r%0d_mem_wdata", i), Mem_Wdata, tbl[i].xd);
      check_output($sformatf("r%0d_core_rdata", i), Core_Rdata, tbl[i].xc);
      check_output($sformatf("r%0d_nic_rdata", i), Nic_Rdata, tbl[i].xn);
      check_output($sformatf("r%0d_nic_rvalid", i), 64'(Nic_Rvalid), 64'(tbl[i].xv));
    end

    // Build up to a forced slot, then drop Nic_Req inside it.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 1, 0, 8'h16, 0, 1, 0, 8'h44, 0);
      check_output($sformatf("drop_pre%0d_gnt", k), 64'({Nic_Gnt, Core_Stall}), 64'b00);
    end
    apply_stimulus(0, 1, 0, 8'h16, 0, 0, 0, 8'h44, 0);
    check_output("drop_slot_gnt_stall", 64'({Nic_Gnt, Core_Stall}), 64'b00);
    check_output("drop_slot_mem", 64'({Mem_En, Mem_WrEn, Mem_Addr}), 64'({1'b1, 1'b0, 8'h16}));
    // A cleared counter needs a full STARVE_MAX denials again.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 1, 0, 8'h17, 0, 1, 0, 8'h44, 0);
      check_output($sformatf("drop_post%0d_gnt", k), 64'({Nic_Gnt, Core_Stall}), 64'b00);
    end
    apply_stimulus(0, 1, 0, 8'h17, 0, 1, 0, 8'h44, 0);
    check_output("refire_gnt_stall", 64'({Nic_Gnt, Core_Stall}), 64'b11);
    check_output("refire_mem_addr", 64'(Mem_Addr), 64'h44);
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    check_output("refire_nic_rvalid", 64'(Nic_Rvalid), 64'd1);
    check_output("refire_nic_rdata", Nic_Rdata, m(8'h44));

    // Reset arriving while a NIC read is in flight drops the data.
    apply_stimulus(0, 0, 0, 8'h00, 0, 1, 0, 8'h43, 0);
    check_output("midrd_gnt", 64'(Nic_Gnt), 64'd1);
    apply_stimulus(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    check_output("midrd_rst_rvalid", 64'(Nic_Rvalid), 64'd0);
    check_output("midrd_rst_rdata", Nic_Rdata, 64'd0);
    apply_stimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
    check_output("midrd_after_rvalid", 64'(Nic_Rvalid), 64'd0);
    check_output("midrd_after_rdata", Nic_Rdata, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
